// File: rtl/streaming_conv_layer.sv
// streaming_conv_layer
//   Streaming 2-D convolution over a raster-order pixel stream. Each input
//   channel keeps F-1 line buffers plus an FxF window. Every output channel
//   then forms a signed multiply-accumulate over all input channels and
//   saturates the result to Q_WIDTH bits.
//
//   Pipeline, counted in clk_en cycles:
//     E0 (the accepting edge): window shift, products registered
//     E1: full-precision sum registered
//     E2: saturated (optionally ReLU'd) result registered, out_valid high
//
//   Optional feature: define CONV_RELU_EN to clamp negative results to 0.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clk_en          global enable; low freezes all state
//   in_valid        input_data holds a pixel (accepted when clk_en & in_valid)
//   input_data      D_CHANNELS x D_WIDTH packed pixels, channel 0 in the LSBs
//   wt_wr_en        weight write strobe
//   wt_addr         weight index ((q*D_CHANNELS+d)*F+r)*F+c
//   wt_data         weight value
//   output_data     Q_CHANNELS x Q_WIDTH packed results, channel 0 in the LSBs
//   out_valid       single-cycle strobe qualifying output_data
//   frame_done      strobe aligned with the last pixel's pipeline output

module streaming_conv_lane #(
  parameter int D_WIDTH = 8,
  parameter int W_WIDTH = 8,
  parameter int Q_WIDTH = 16,
  parameter int K       = 9
) (
  input  logic                      clk,
  input  logic                      clk_en,
  input  logic                      ld_i,   // sum_q holds a valid window sum
  input  logic                      rst,
  input  logic [K-1:0][D_WIDTH-1:0] win_i,  // window as seen at the accepting edge
  input  logic [K-1:0][W_WIDTH-1:0] wt_i,
  output logic [Q_WIDTH-1:0]        q_o
);
  localparam int PW  = D_WIDTH + W_WIDTH;
  localparam int SW0 = PW + $clog2(K) + 1;
  localparam int SW  = (SW0 > Q_WIDTH) ? SW0 : Q_WIDTH + 1;
  localparam logic signed [SW-1:0] QMAX = {{(SW-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] QMIN = {{(SW-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] prod_q [K];
  logic signed [SW-1:0] sum_d, sum_q;
  logic [Q_WIDTH-1:0]   res_d, out_q;

  always_ff @(posedge clk) begin
    if (clk_en) begin
      for (int k = 0; k < K; k++)
        prod_q[k] <= PW'($signed(win_i[k])) * PW'($signed(wt_i[k]));
      sum_q <= sum_d;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < K; k++) sum_d = sum_d + SW'(prod_q[k]);
  end

  always_comb begin
    res_d = sum_q[Q_WIDTH-1:0];
    if (sum_q > QMAX)      res_d = QMAX[Q_WIDTH-1:0];
    else if (sum_q < QMIN) res_d = QMIN[Q_WIDTH-1:0];
`ifdef CONV_RELU_EN
    if (res_d[Q_WIDTH-1]) res_d = '0;
`endif
  end

  // output_data holds its last value between strobes
  always_ff @(posedge clk) begin
    if (rst)                out_q <= '0;
    else if (clk_en && ld_i) out_q <= res_d;
  end

  assign q_o = out_q;
endmodule

module streaming_conv_layer #(
  parameter int D_WIDTH     = 8,
  parameter int W_WIDTH     = 8,
  parameter int Q_WIDTH     = 16,
  parameter int D_CHANNELS  = 1,
  parameter int Q_CHANNELS  = 1,
  parameter int FILTER_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int STRIDE      = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            clk_en,
  input  logic                                            in_valid,
  input  logic [D_WIDTH*D_CHANNELS-1:0]                   input_data,
  input  logic                                            wt_wr_en,
  input  logic [$clog2(Q_CHANNELS*D_CHANNELS*FILTER_SIZE*FILTER_SIZE)-1:0] wt_addr,
  input  logic [W_WIDTH-1:0]                              wt_data,
  output logic [Q_WIDTH*Q_CHANNELS-1:0]                   output_data,
  output logic                                            out_valid,
  output logic                                            frame_done
);
  localparam int F      = FILTER_SIZE;
  localparam int N      = IMAGE_SIZE;
  localparam int K      = D_CHANNELS * F * F;
  localparam int NW     = Q_CHANNELS * K;
  localparam int CW     = $clog2(N);
  localparam int STAGES = 2;

  logic [D_CHANNELS-1:0][D_WIDTH-1:0] px;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic          acc, emit, last_px;
  logic [STAGES:0] vld_pipe, fd_pipe;

  logic [D_WIDTH-1:0] lb_q  [D_CHANNELS][F-1][N];
  logic [D_WIDTH-1:0] win_q [D_CHANNELS][F][F];
  logic [D_WIDTH-1:0] win_d [D_CHANNELS][F][F];
  logic [K-1:0][D_WIDTH-1:0] win_flat;
  logic [NW-1:0][W_WIDTH-1:0] wt_q;

  assign px      = input_data;
  assign acc     = clk_en && in_valid;
  assign last_px = (row_q == CW'(N-1)) && (col_q == CW'(N-1));

  // Position counters of the next pixel to arrive.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (acc) begin
      if (col_q == CW'(N-1)) begin
        col_d = '0;
        row_d = (row_q == CW'(N-1)) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window anchored at the current pixel as bottom-right corner; no padding.
  always_comb begin
    emit = (row_q >= CW'(F-1)) && (col_q >= CW'(F-1));
    if (((int'(row_q) - (F-1)) % STRIDE) != 0) emit = 1'b0;
    if (((int'(col_q) - (F-1)) % STRIDE) != 0) emit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      col_q    <= '0;
      vld_pipe <= '0;
      fd_pipe  <= '0;
    end else if (clk_en) begin
      row_q    <= row_d;
      col_q    <= col_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], acc && emit};
      fd_pipe  <= {fd_pipe[STAGES-1:0], acc && last_px};
    end
  end

  // The new right-hand column comes from the line buffers (older rows, same
  // column) with the incoming pixel at the bottom.
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int d = 0; d < D_CHANNELS; d++) begin
        for (int r = 0; r < F; r++)
          for (int c = 0; c < F-1; c++)
            win_d[d][r][c] = win_q[d][r][c+1];
        for (int r = 0; r < F-1; r++)
          win_d[d][r][F-1] = lb_q[d][r][col_q];
        win_d[d][F-1][F-1] = px[d];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int d = 0; d < D_CHANNELS; d++)
      for (int r = 0; r < F; r++)
        for (int c = 0; c < F; c++)
          win_flat[(d*F+r)*F+c] = win_d[d][r][c];
  end

  // Data storage is deliberately not reset: stale line-buffer rows are never
  // read into an emitted window because the counters restart at zero.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      win_q <= win_d;
      if (acc) begin
        for (int d = 0; d < D_CHANNELS; d++) begin
          for (int k = 0; k < F-2; k++)
            lb_q[d][k][col_q] <= lb_q[d][k+1][col_q];
          lb_q[d][F-2][col_q] <= px[d];
        end
      end
      // Products sample wt_q before this edge, so a write coinciding with an
      // accept only affects later pixels.
      if (wt_wr_en && (int'(wt_addr) < NW)) wt_q[wt_addr] <= wt_data;
    end
  end

  for (genvar q = 0; q < Q_CHANNELS; q++) begin : g_lane
    streaming_conv_lane #(
      .D_WIDTH(D_WIDTH), .W_WIDTH(W_WIDTH), .Q_WIDTH(Q_WIDTH), .K(K)
    ) u_lane (
      .clk    (clk),
      .clk_en (clk_en),
      .ld_i   (vld_pipe[STAGES-1]),
      .rst    (rst),
      .win_i  (win_flat),
      .wt_i   (wt_q[q*K +: K]),
      .q_o    (output_data[q*Q_WIDTH +: Q_WIDTH])
    );
  end

  assign out_valid  = vld_pipe[STAGES];
  assign frame_done = fd_pipe[STAGES];
endmodule

// File: tb/tb_streaming_conv_layer.sv
// Two instances share one stimulus stream: stride 1 and stride 2, both with
// N=5, F=3, two input and two output channels, and 8-bit outputs so that
// saturation is reachable. The expected results come from a model that
// holds the whole image and the weight table and evaluates the convolution
// directly from the window definition.
module tb_streaming_conv_layer;
  localparam int N  = 5;
  localparam int F  = 3;
  localparam int DC = 2;
  localparam int QC = 2;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int QW = 8;
  localparam int NW = QC * DC * F * F;
  localparam int AW = $clog2(NW);
  localparam int OW = QW * QC;

  logic clk, rst, clk_en, in_valid, wt_wr_en;
  logic [DW*DC-1:0] input_data;
  logic [AW-1:0]    wt_addr;
  logic [WW-1:0]    wt_data;
  logic [OW-1:0]    od [2];
  logic             ov [2];
  logic             fdn [2];

  streaming_conv_layer #(.D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW), .D_CHANNELS(DC),
    .Q_CHANNELS(QC), .FILTER_SIZE(F), .IMAGE_SIZE(N), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .input_data(input_data),
    .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .output_data(od[0]), .out_valid(ov[0]), .frame_done(fdn[0]));

  streaming_conv_layer #(.D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW), .D_CHANNELS(DC),
    .Q_CHANNELS(QC), .FILTER_SIZE(F), .IMAGE_SIZE(N), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .input_data(input_data),
    .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .output_data(od[1]), .out_valid(ov[1]), .frame_done(fdn[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          win;
    bit          fd;
    logic [OW-1:0] val;
  } exp_t;

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int pos      = 0;
  int img [DC][N*N];
  int wtm [NW];
  exp_t eq [2][64];
  int hd [2], tl [2], npulse [2], nfd [2];
  logic [OW-1:0] last [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    int r;
    r = (v > 127) ? 127 : (v < -128) ? -128 : v;
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // Window with bottom-right corner at (r,c), evaluated straight from the image.
  function automatic logic [OW-1:0] conv_at(input int r, input int c);
    logic [OW-1:0] v;
    int s;
    v = '0;
    for (int q = 0; q < QC; q++) begin
      s = 0;
      for (int d = 0; d < DC; d++)
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            s += img[d][(r-F+1+i)*N + (c-F+1+j)] * wtm[((q*DC+d)*F+i)*F+j];
      v[q*QW +: QW] = QW'(sat(s));
    end
    return v;
  endfunction

  // One clock; the model consumes whatever the stimulus drove before it.
  task automatic tick();
    int r, c, st;
    bit w, ev, ef;
    @(posedge clk);
    #1;
    if (rst) begin
      pos = 0;
      for (int s = 0; s < 2; s++) begin
        hd[s] = 0; tl[s] = 0; last[s] = '0;
        chk("rst_out_valid", 32'(ov[s]), 0);
        chk("rst_frame_done", 32'(fdn[s]), 0);
        chk("rst_output_data", 32'(od[s]), 0);
      end
    end else if (clk_en) begin
      ecnt++;
      if (in_valid) begin
        for (int d = 0; d < DC; d++) img[d][pos] = $signed(input_data[d*DW +: DW]);
        r = pos / N;
        c = pos % N;
        for (int s = 0; s < 2; s++) begin
          st = s + 1;
          w = (r >= F-1) && (c >= F-1) && ((r-F+1) % st == 0) && ((c-F+1) % st == 0);
          if (w || pos == N*N-1) begin
            eq[s][tl[s]].due = ecnt + 2;
            eq[s][tl[s]].win = w;
            eq[s][tl[s]].fd  = (pos == N*N-1);
            eq[s][tl[s]].val = w ? conv_at(r, c) : '0;
            tl[s] = (tl[s] + 1) % 64;
          end
        end
        pos = (pos == N*N-1) ? 0 : pos + 1;
      end
      if (wt_wr_en && int'(wt_addr) < NW) wtm[wt_addr] = $signed(wt_data);
      for (int s = 0; s < 2; s++) begin
        ev = 0; ef = 0;
        if (hd[s] != tl[s] && eq[s][hd[s]].due == ecnt) begin
          ev = eq[s][hd[s]].win;
          ef = eq[s][hd[s]].fd;
          if (ev) last[s] = eq[s][hd[s]].val;
          hd[s] = (hd[s] + 1) % 64;
        end
        chk(s == 0 ? "out_valid_s1" : "out_valid_s2", 32'(ov[s]), 32'(ev));
        chk(s == 0 ? "frame_done_s1" : "frame_done_s2", 32'(fdn[s]), 32'(ef));
        chk(s == 0 ? "output_data_s1" : "output_data_s2", 32'(od[s]), 32'(last[s]));
        if (ov[s] === 1'b1) npulse[s]++;
        if (fdn[s] === 1'b1) nfd[s]++;
      end
    end else begin
      for (int s = 0; s < 2; s++) chk("frozen_output_data", 32'(od[s]), 32'(last[s]));
    end
  endtask

  task automatic idle(input int n);
    rst = 0; clk_en = 1; in_valid = 0; wt_wr_en = 0;
    repeat (n) tick();
  endtask

  task automatic load_w(input int mode);
    rst = 0; clk_en = 1; in_valid = 0; wt_wr_en = 1;
    for (int a = 0; a < NW; a++) begin
      wt_addr = AW'(a);
      case (mode)
        0:       wt_data = 8'd1;
        1:       wt_data = WW'($urandom_range(7) - 4);
        2:       wt_data = 8'sd127;
        default: wt_data = 8'h80;
      endcase
      tick();
    end
    wt_addr = AW'(40);  // outside the table, must be ignored
    wt_data = 8'h55;
    tick();
    wt_wr_en = 0;
  endtask

  function automatic int pixval(input int mode, input int idx, input int d);
    case (mode)
      1:       return (d == 0) ? idx % 9 : -(idx % 4);
      2:       return int'($urandom_range(7)) - 4;
      3:       return 127;
      default: return 1;
    endcase
  endfunction

  // mode 4: in_valid toggles every cycle and clk_en drops for 3 cycles.
  task automatic feed(input int mode, input int npx, input int pen, input int pvld, input bit rwr);
    int acc_n, it;
    acc_n = 0;
    it = 0;
    while (acc_n < npx && it < 2000) begin
      rst = 0;
      if (mode == 4) begin
        clk_en   = !(it >= 15 && it < 18);
        in_valid = (it % 2 == 0);
      end else begin
        clk_en   = ($urandom_range(99) < pen);
        in_valid = ($urandom_range(99) < pvld);
      end
      for (int d = 0; d < DC; d++) input_data[d*DW +: DW] = DW'(pixval(mode, acc_n, d));
      wt_wr_en = rwr && ($urandom_range(99) < 20);
      wt_addr  = AW'($urandom_range(63));
      wt_data  = WW'($urandom_range(7) - 4);
      tick();
      if (clk_en && in_valid) acc_n++;
      it++;
    end
    wt_wr_en = 0; in_valid = 0; clk_en = 1;
  endtask

  task automatic frame(input int mode, input int pen, input int pvld, input bit rwr);
    for (int s = 0; s < 2; s++) begin npulse[s] = 0; nfd[s] = 0; end
    feed(mode, N*N, pen, pvld, rwr);
    idle(4);
    chk("pulses_s1", 32'(npulse[0]), 9);
    chk("pulses_s2", 32'(npulse[1]), 4);
    chk("frame_done_cnt_s1", 32'(nfd[0]), 1);
    chk("frame_done_cnt_s2", 32'(nfd[1]), 1);
  endtask

  initial begin
    rst = 1; clk_en = 0; in_valid = 0; wt_wr_en = 0;
    input_data = '0; wt_addr = '0; wt_data = '0;
    for (int s = 0; s < 2; s++) begin hd[s] = 0; tl[s] = 0; last[s] = '0; end
    tick();
    tick();

    // Unit weights, constant pixels: every window sums to 2*9 = 18 per output.
    load_w(0);
    frame(0, 100, 100, 0);
    chk("const_sum_s1", 32'(od[0]), 32'h1212);
    chk("const_sum_s2", 32'(od[1]), 32'h1212);

    // Same frame under in_valid bubbles and a clk_en freeze.
    frame(4, 100, 100, 0);
    chk("bubble_sum_s1", 32'(od[0]), 32'h1212);

    // Random weights and pixels, random gaps, weight writes during the frame.
    load_w(1);
    frame(2, 85, 70, 1);
    frame(1, 100, 100, 0);

    // Saturation in both directions.
    load_w(2);
    frame(3, 100, 100, 0);
    chk("sat_pos", 32'(od[0]), 32'h7f7f);
    load_w(3);
    frame(3, 100, 100, 0);
`ifdef CONV_RELU_EN
    chk("sat_neg", 32'(od[0]), 32'h0000);
`else
    chk("sat_neg", 32'(od[0]), 32'h8080);
`endif

    // Reset with results in flight (pixel (2,2) just accepted), clk_en low.
    load_w(0);
    feed(2, 13, 100, 100, 0);
    rst = 1; clk_en = 0; in_valid = 0;
    tick();
    idle(3);
    frame(0, 100, 100, 0);
    chk("post_rst_sum", 32'(od[0]), 32'h1212);

    load_w(1);
    frame(2, 80, 60, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/streaming_conv_layer.md
STREAMING_CONV_LAYER -- requirements
Module: streaming_conv_layer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: signed input pixel width per channel.
REQ-002 SHALL have parameter W_WIDTH, default 8: signed weight width.
REQ-003 SHALL have parameter Q_WIDTH, default 16: signed output width per channel.
REQ-004 SHALL have parameter D_CHANNELS, default 1: input channel count.
REQ-005 SHALL have parameter Q_CHANNELS, default 1: output channel count.
REQ-006 SHALL have parameter FILTER_SIZE, default 3: square kernel side F (F>=2).
REQ-007 SHALL have parameter IMAGE_SIZE, default 8: square image side N (N>=F).
REQ-008 SHALL have parameter STRIDE, default 1: window step in rows and columns.
REQ-009 clk  in  1  sole clock, all state on rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 clk_en  in  1  global enable; low freezes every register, including the weight store.
REQ-012 in_valid  in  1  input_data carries one raster-order pixel; accepted when clk_en&in_valid.
REQ-013 input_data  in  D_WIDTH*D_CHANNELS  channel d at bits [D_WIDTH*(d+1)-1 : D_WIDTH*d].
REQ-014 wt_wr_en  in  1  weight write strobe, taken when clk_en high.
REQ-015 wt_addr  in  clog2(Q_CHANNELS*D_CHANNELS*F*F)  weight index ((q*D_CHANNELS+d)*F+r)*F+c.
REQ-016 wt_data  in  W_WIDTH  weight value.
REQ-017 output_data  out  Q_WIDTH*Q_CHANNELS  channel q at bits [Q_WIDTH*(q+1)-1 : Q_WIDTH*q].
REQ-018 out_valid  out  1  single-cycle strobe qualifying output_data.
REQ-019 frame_done  out  1  single-cycle strobe on the cycle of the frame's last accepted pixel's pipeline output.

Function
REQ-020 SHALL track row and col counters (0..N-1) of the next pixel, advancing only on accepted pixels; col wraps N-1->0 and increments row; row wraps N-1->0 (frame wrap).
REQ-021 SHALL hold F-1 line buffers of N pixels per input channel plus an FxF window register per channel, shifting only on accepted pixels.
REQ-022 Window element (r,c) SHALL be pixel at (row-F+1+r, col-F+1+c) of the just-accepted pixel; r=0 top, c=0 left.
REQ-023 A window SHALL be emitted iff row>=F-1, col>=F-1, (row-F+1)%STRIDE==0 and (col-F+1)%STRIDE==0; no padding, windows never span row or frame boundaries.
REQ-024 Per output q: sum over d,r,c of signed pixel*signed weight, full precision, SHALL then saturate to Q_WIDTH signed range.
REQ-025 Latency SHALL be exactly 2 enabled cycles from the accepting edge to the edge asserting out_valid (stage 1: window/products, stage 2: sum/saturate registered).
REQ-026 Pipeline stages SHALL advance on every clk_en cycle; in_valid low inserts a bubble (out_valid low), no stall of earlier results.
REQ-027 output_data SHALL hold its last value while out_valid is low.
REQ-028 frame_done SHALL assert with the output of pixel (N-1,N-1), whether or not that pixel produced a window.
REQ-029 Weight write SHALL take effect for windows computed at least one cycle after the write edge; write and pixel accept in the same cycle use the old weight.
REQ-030 wt_addr beyond range SHALL be ignored.

Reset
REQ-031 rst SHALL clear row, col, window valid pipeline, out_valid=0, frame_done=0, output_data=0, regardless of clk_en.
REQ-032 rst SHALL NOT clear weight store or line-buffer contents; first frame after rst emits no window until REQ-023 holds with fresh pixels.
REQ-033 rst asserted mid-frame SHALL discard in-flight results; out_valid low the cycle after rst.

Configuration
REQ-034 Macro CONV_RELU_EN defined: after saturation, negative results SHALL be replaced by 0.
REQ-035 CONV_RELU_EN undefined: saturated signed result SHALL be output unchanged.

Verification
REQ-036 N=4,F=3,STRIDE=1,D=Q=1, all weights 1, 16 pixels of 1 -> 4 out_valid pulses each 9, frame_done with the 4th.
REQ-037 N=5,F=3,STRIDE=2, weights 1, pixel value=raster index -> 4 outputs 54,72,144,162.
REQ-038 Q_WIDTH=8, weights 127, pixels 127, F=3 -> output 127; weights -128, pixels 127 -> -128 (0 with CONV_RELU_EN).
REQ-039 D=2,Q=2, ch0 weights 1, ch1 weights -1 per q, pixels (2,1) on N=3 -> q0=9... q0 and q1 both 9 when q1 uses (1,1) weights with pixels (1,0); checks packing/addressing.
REQ-040 in_valid toggling 1/0 and clk_en low for 3 cycles mid-frame -> identical output sequence as REQ-036, latency 2 enabled cycles.
REQ-041 rst after 6 pixels, then full frame -> no outputs from partial frame, then exactly REQ-036 response.
